// File: rtl/digit_entry_if.sv
// Keypad-encoder handshake: BCD key code and active-low valid toward the
// entry logic, active-low enable back to the encoder.
interface digit_entry_if;
  logic [3:0] digit;
  logic       validn;
  logic       enablen;

  modport master (output digit, output validn, input enablen);
  modport slave  (input digit, input validn, output enablen);
endinterface

// File: rtl/digit_entry.sv
// Debounced keypad digit entry for a cooking timer: each accepted key shifts
// a BCD digit into an MM:SS register, and a held key is accepted only once.
module digit_entry #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset,
  digit_entry_if.slave kp,
  input  logic         load_enable,
  input  logic         clear_entry,
  output logic [3:0]   min_tens,
  output logic [3:0]   min_ones,
  output logic [3:0]   sec_tens,
  output logic [3:0]   sec_ones,
  output logic [2:0]   digit_count,
  output logic         key_ack,
  output logic         key_reject,
  output logic         time_nonzero
);

  typedef enum logic [1:0] {IDLE, PRESS_DB, COMMIT, RELEASE_DB} state_t;

  localparam logic [4:0] DB_LIMIT = 5'(DEBOUNCE_CYCLES);
  // A freshly captured key already counts as one stable sample.
  localparam state_t AFTER_CAPTURE = (DEBOUNCE_CYCLES == 1) ? COMMIT : PRESS_DB;

  state_t     state_reg, state_next;
  logic [3:0] db_count_reg, db_count_next;
  logic [3:0] held_reg, held_next;
  logic [4:0] db_inc;
  logic       commit;

  logic [3:0] digits_reg [4];   // [3]=min_tens ... [0]=sec_ones
  logic [2:0] digit_count_reg;
  logic       ack_reg, reject_reg;
  logic       accept, reject;
  logic [3:0] digit_nz;

  assign kp.enablen = ~load_enable;
  assign db_inc     = {1'b0, db_count_reg} + 5'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      db_count_reg <= '0;
      held_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      db_count_reg <= db_count_next;
      held_reg     <= held_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    db_count_next = db_count_reg;
    held_next     = held_reg;
    commit        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!kp.validn) begin
          held_next     = kp.digit;
          db_count_next = 4'd1;
          state_next    = AFTER_CAPTURE;
        end
      end
      PRESS_DB: begin
        if (kp.validn) begin
          state_next = IDLE;
        end else if (kp.digit != held_reg) begin
          held_next     = kp.digit;
          db_count_next = 4'd1;
          state_next    = AFTER_CAPTURE;
        end else begin
          db_count_next = db_inc[3:0];
          if (db_inc >= DB_LIMIT) state_next = COMMIT;
        end
      end
      COMMIT: begin
        commit        = 1'b1;
        db_count_next = '0;
        state_next    = RELEASE_DB;
      end
      RELEASE_DB: begin
        if (!kp.validn) begin
          db_count_next = '0;
        end else if (db_inc >= DB_LIMIT) begin
          db_count_next = '0;
          state_next    = IDLE;
        end else begin
          db_count_next = db_inc[3:0];
        end
      end
      default: state_next = IDLE;
    endcase
    // Losing entry permission abandons whatever key handling was under way.
    if (!load_enable) begin
      state_next    = IDLE;
      db_count_next = '0;
      commit        = 1'b0;
    end
  end

  // A cancel in the commit cycle swallows the key without any pulse.
  assign accept = commit && !clear_entry && (held_reg <= 4'd9) && (digit_count_reg < 3'd4);
  assign reject = commit && !clear_entry && !accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) digits_reg[i] <= '0;
      digit_count_reg <= '0;
      ack_reg         <= 1'b0;
      reject_reg      <= 1'b0;
    end else begin
      ack_reg    <= accept;
      reject_reg <= reject;
      if (clear_entry) begin
        for (int i = 0; i < 4; i++) digits_reg[i] <= '0;
        digit_count_reg <= '0;
      end else if (accept) begin
        digits_reg[0] <= held_reg;
        for (int i = 1; i < 4; i++) digits_reg[i] <= digits_reg[i-1];
        digit_count_reg <= digit_count_reg + 3'd1;
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_nz
    assign digit_nz[gi] = |digits_reg[gi];
  end

  assign time_nonzero = |digit_nz;
  assign min_tens     = digits_reg[3];
  assign min_ones     = digits_reg[2];
  assign sec_tens     = digits_reg[1];
  assign sec_ones     = digits_reg[0];
  assign digit_count  = digit_count_reg;
  assign key_ack      = ack_reg;
  assign key_reject   = reject_reg;

endmodule

// File: tb/tb_digit_entry.sv
// Bench for digit_entry: a cycle table, hand-written corner sequences, and
// random press/release streams checked against a press-level model.
module tb_digit_entry;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       reset, load_enable, clear_entry;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [2:0] digit_count;
  logic       key_ack, key_reject, time_nonzero;

  digit_entry_if kp ();

  digit_entry #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .kp(kp),
    .load_enable(load_enable), .clear_entry(clear_entry),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .digit_count(digit_count), .key_ack(key_ack), .key_reject(key_reject),
    .time_nonzero(time_nonzero)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int ack_seen = 0;
  int rej_seen = 0;

  typedef struct {
    logic       rst, le, clr, vn;
    logic [3:0] d;
    logic       ack, rej;
    logic [2:0] cnt;
    logic [3:0] so;
    logic       en;
  } vec_t;

  vec_t vecs [19];

  logic       smp_v   [0:1023];
  logic [3:0] smp_d   [0:1023];
  bit         exp_ack [0:1023];
  bit         exp_rej [0:1023];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    if (key_ack) ack_seen++;
    if (key_reject) rej_seen++;
  endtask

  task automatic drive(input logic vn, input logic [3:0] d, input int n);
    kp.validn = vn;
    kp.digit  = d;
    repeat (n) cycle();
  endtask

  task automatic press(input logic [3:0] d, input int lo, input int hi);
    drive(1'b0, d, lo);
    drive(1'b1, 4'd0, hi);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_entry = 1'b0;
    load_enable = 1'b1;
    kp.validn = 1'b1;
    cycle();
    reset = 1'b0;
    ack_seen = 0;
    rej_seen = 0;
  endtask

  function automatic vec_t mk(input logic rst, input logic le, input logic clr, input logic vn,
                              input logic [3:0] d, input logic ack, input logic rej,
                              input logic [2:0] cnt, input logic [3:0] so, input logic en);
    vec_t v;
    v.rst = rst; v.le = le; v.clr = clr; v.vn = vn; v.d = d;
    v.ack = ack; v.rej = rej; v.cnt = cnt; v.so = so; v.en = en;
    return v;
  endfunction

  // The model works per key press: a press is taken when the key was released
  // long enough beforehand and stays steady for DB samples; the entered time
  // is kept as a decimal number that grows by one digit per accepted key.
  task automatic random_round(input int round, input int nseg);
    int t, c, len, n_model, c_model, commit_s;
    bit armed;
    logic [3:0] d;
    for (int i = 0; i < 1024; i++) begin
      exp_ack[i] = 1'b0;
      exp_rej[i] = 1'b0;
    end
    t = 0; armed = 1'b1; commit_s = -1; n_model = 0; c_model = 0;
    for (int s = 0; s < nseg; s++) begin
      len = int'($urandom_range(1, 8));
      d = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      for (int k = 0; k < len; k++) begin
        smp_v[t+k] = 1'b0;
        smp_d[t+k] = d;
      end
      if (armed && len >= DB) begin
        c = t + DB;
        if (d <= 4'd9 && c_model < 4) begin
          exp_ack[c] = 1'b1;
          n_model = n_model * 10 + int'(d);
          c_model++;
        end else begin
          exp_rej[c] = 1'b1;
        end
        armed = 1'b0;
        commit_s = c;
      end
      t += len;
      len = (s == nseg - 1) ? DB + 2 : int'($urandom_range(1, 8));
      for (int k = 0; k < len; k++) begin
        smp_v[t+k] = 1'b1;
        smp_d[t+k] = 4'($urandom_range(0, 15));
      end
      // The commit cycle itself does not count toward the release.
      if (!armed && (len - ((commit_s == t) ? 1 : 0)) >= DB) armed = 1'b1;
      t += len;
    end
    do_reset();
    for (int s = 0; s < t; s++) begin
      kp.validn = smp_v[s];
      kp.digit  = smp_d[s];
      cycle();
      check("rnd_pulse", 32'({key_ack, key_reject}), 32'({exp_ack[s], exp_rej[s]}));
    end
    check("rnd_digits", 32'({min_tens, min_ones, sec_tens, sec_ones}),
          32'({4'((n_model / 1000) % 10), 4'((n_model / 100) % 10),
               4'((n_model / 10) % 10), 4'(n_model % 10)}));
    check("rnd_count", 32'(digit_count), 32'(c_model));
    check("rnd_nonzero", 32'(time_nonzero), 32'(n_model != 0));
    $display("round %0d: %0d samples, time=%0d count=%0d", round, t, n_model, c_model);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; load_enable = 1'b1; clear_entry = 1'b0;
    kp.validn = 1'b1; kp.digit = 4'd0;

    vecs[0]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
    for (int i = 1; i <= 4; i++)
      vecs[i] = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
    vecs[5]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd8,  1'b1, 1'b0, 3'd1, 4'd8, 1'b0);
    vecs[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd8,  1'b0, 1'b0, 3'd1, 4'd8, 1'b0);
    for (int i = 7; i <= 10; i++)
      vecs[i] = mk(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 3'd1, 4'd8, 1'b0);
    for (int i = 11; i <= 14; i++)
      vecs[i] = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd11, 1'b0, 1'b0, 3'd1, 4'd8, 1'b0);
    vecs[15] = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd11, 1'b0, 1'b1, 3'd1, 4'd8, 1'b0);
    vecs[16] = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 3'd1, 4'd8, 1'b1);
    vecs[17] = mk(1'b0, 1'b1, 1'b1, 1'b1, 4'd0,  1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
    vecs[18] = mk(1'b0, 1'b1, 1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 3'd0, 4'd0, 1'b0);

    for (int i = 0; i < 19; i++) begin
      reset = vecs[i].rst; load_enable = vecs[i].le; clear_entry = vecs[i].clr;
      kp.validn = vecs[i].vn; kp.digit = vecs[i].d;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i),
            32'({key_ack, key_reject, digit_count, sec_ones, kp.enablen}),
            32'({vecs[i].ack, vecs[i].rej, vecs[i].cnt, vecs[i].so, vecs[i].en}));
      $display("vec %0d: vn=%0b d=%0d ack=%0b rej=%0b cnt=%0d", i, vecs[i].vn, vecs[i].d,
               key_ack, key_reject, digit_count);
    end

    // Full entry 12:30, then a fifth key that does not fit.
    do_reset();
    check("reset_outputs", 32'({min_tens, min_ones, sec_tens, sec_ones, digit_count,
                                key_ack, key_reject, time_nonzero}), 32'd0);
    press(4'd1, 6, 6); press(4'd2, 6, 6); press(4'd3, 6, 6); press(4'd0, 6, 6);
    check("entry_acks", 32'(ack_seen), 32'd4);
    check("entry_digits", 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'h1230);
    check("entry_count", 32'(digit_count), 32'd4);
    press(4'd5, 6, 6);
    check("full_reject", 32'(rej_seen), 32'd1);
    check("full_acks", 32'(ack_seen), 32'd4);
    check("full_digits", 32'({min_tens, min_ones, sec_tens, sec_ones, digit_count}),
          32'({16'h1230, 3'd4}));
    $display("entry 12:30 then 5: acks=%0d rejects=%0d", ack_seen, rej_seen);

    // Short glitch is ignored; the next clean press has the nominal latency.
    do_reset();
    drive(1'b0, 4'd2, 3);
    drive(1'b1, 4'd0, 3);
    check("glitch_pulses", 32'(ack_seen + rej_seen), 32'd0);
    kp.validn = 1'b0; kp.digit = 4'd6;
    for (int k = 0; k <= DB; k++) begin
      cycle();
      check($sformatf("latency%0d", k), 32'(key_ack), 32'(k == DB));
    end
    drive(1'b1, 4'd0, 6);
    $display("glitch then press 6: sec_ones=%0d", sec_ones);

    // A long hold is accepted once; release and re-press gives a second key.
    do_reset();
    drive(1'b0, 4'd7, 50);
    check("hold_acks", 32'(ack_seen), 32'd1);
    check("hold_digit", 32'(sec_ones), 32'd7);
    drive(1'b1, 4'd0, 6);
    press(4'd7, 6, 6);
    check("repress_acks", 32'(ack_seen), 32'd2);
    check("repress_digits", 32'({sec_tens, sec_ones, digit_count}), 32'({8'h77, 3'd2}));
    $display("hold 7 x50 then re-press: acks=%0d", ack_seen);

    // Cancel landing exactly on the commit cycle of a 9.
    do_reset();
    press(4'd5, 6, 6);
    check("nonzero_before_clear", 32'(time_nonzero), 32'd1);
    kp.validn = 1'b0; kp.digit = 4'd9;
    for (int k = 0; k <= DB + 1; k++) begin
      clear_entry = (k == DB);
      cycle();
    end
    clear_entry = 1'b0;
    drive(1'b1, 4'd0, 6);
    check("clear_pulses", 32'({ack_seen[7:0], rej_seen[7:0]}), 32'({8'd1, 8'd0}));
    check("clear_state", 32'({min_tens, min_ones, sec_tens, sec_ones, digit_count,
                              time_nonzero}), 32'd0);
    $display("clear on commit of 9: count=%0d nonzero=%0b", digit_count, time_nonzero);

    // Entry disabled, then reset in the middle of a press.
    do_reset();
    press(4'd3, 6, 6);
    load_enable = 1'b0;
    #1;
    check("enablen_high", 32'(kp.enablen), 32'd1);
    drive(1'b0, 4'd4, 8);
    check("disabled_acks", 32'(ack_seen), 32'd1);
    check("disabled_digits", 32'({sec_ones, digit_count}), 32'({4'd3, 3'd1}));
    load_enable = 1'b1;
    drive(1'b1, 4'd0, 2);
    check("enablen_low", 32'(kp.enablen), 32'd0);
    drive(1'b0, 4'd4, 2);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("midpress_reset", 32'({min_tens, min_ones, sec_tens, sec_ones, digit_count,
                                 key_ack, key_reject, time_nonzero}), 32'd0);
    for (int k = 0; k <= DB; k++) begin
      cycle();
      check($sformatf("afresh%0d", k), 32'(key_ack), 32'(k == DB));
    end
    check("afresh_digit", 32'(sec_ones), 32'd4);
    drive(1'b1, 4'd0, 6);
    $display("disable + mid-press reset: sec_ones=%0d", sec_ones);

    for (int r = 0; r < 10; r++) random_round(r, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/digit_entry.md
DIGIT_ENTRY -- requirements
Module: digit_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable samples required to accept a press or a release (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port digit, input, 4 bits, encoded BCD key value from the keypad encoder.
REQ-005 SHALL have port validn, input, 1 bit, active-low "digit is valid" from the keypad encoder.
REQ-006 SHALL have port load_enable, input, 1 bit, high when time entry is permitted (oven idle).
REQ-007 SHALL have port clear_entry, input, 1 bit, cancel key; empties the entry.
REQ-008 SHALL have port enablen, output, 1 bit, active-low enable driven back to the encoder; equals ~load_enable combinationally.
REQ-009 SHALL have ports min_tens, min_ones, sec_tens, sec_ones, output, 4 bits each, registered BCD entered time.
REQ-010 SHALL have port digit_count, output, 3 bits, number of digits accepted (0..4).
REQ-011 SHALL have port key_ack, output, 1 bit, one-cycle pulse per accepted digit.
REQ-012 SHALL have port key_reject, output, 1 bit, one-cycle pulse per debounced press that is discarded.
REQ-013 SHALL have port time_nonzero, output, 1 bit, high when any of the four BCD digits is nonzero.

Function
REQ-014 SHALL implement states IDLE, PRESS_DB, COMMIT, RELEASE_DB.
REQ-015 IDLE: on validn=0 and load_enable=1, SHALL capture digit into an internal holding register, load the debounce counter with 1, and go to PRESS_DB.
REQ-016 PRESS_DB: each cycle with validn=0 and digit equal to the held value SHALL increment the counter; when the counter reaches DEBOUNCE_CYCLES, SHALL go to COMMIT.
REQ-017 PRESS_DB: validn=1 SHALL return to IDLE with no effect; a changed digit with validn=0 SHALL recapture and reload the counter with 1.
REQ-018 COMMIT (one cycle): if held digit <= 9 and digit_count < 4, SHALL shift min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=held digit, increment digit_count, and pulse key_ack; otherwise SHALL leave the digits and count unchanged and pulse key_reject; SHALL then go to RELEASE_DB.
REQ-019 Latency: with validn held low and digit stable from cycle 0, key_ack/key_reject and the updated digits SHALL be visible in cycle DEBOUNCE_CYCLES+1.
REQ-020 RELEASE_DB: SHALL require DEBOUNCE_CYCLES consecutive validn=1 samples before returning to IDLE; any validn=0 SHALL restart the count. A held key is therefore accepted exactly once.
REQ-021 key_ack and key_reject SHALL never be high in the same cycle and SHALL each be high at most one cycle per press.
REQ-022 clear_entry=1 SHALL, on the next edge, zero all four digits and digit_count and suppress any key_ack that cycle; FSM state SHALL be unaffected (a press in progress still requires release).
REQ-023 clear_entry coincident with COMMIT: clear SHALL win; the digits end at zero, digit_count=0, and no key_ack or key_reject is issued.
REQ-024 load_enable=0 in any state SHALL force the FSM to IDLE on the next edge without changing the digits; COMMIT SHALL not occur in a cycle where load_enable=0.
REQ-025 time_nonzero SHALL be combinational from the four registered digits.

Reset
REQ-026 reset=1 SHALL, on the next edge, set FSM=IDLE, all digits=0, digit_count=0, key_ack=0, key_reject=0, and clear the counter and holding register; reset SHALL override clear_entry and all key activity.
REQ-027 reset asserted mid-PRESS_DB or mid-RELEASE_DB SHALL abandon the press; after deassertion a still-held key SHALL be debounced afresh as a new press.

Verification
REQ-028 DEBOUNCE_CYCLES=4; press 1,2,3,0 (each 6 cycles low, 6 high) -> min_tens=1, min_ones=2, sec_tens=3, sec_ones=0, digit_count=4, four key_ack pulses.
REQ-029 After REQ-028 press 5 -> one key_reject pulse, digits unchanged at 12:30, digit_count=4.
REQ-030 validn low for 3 cycles then high (glitch) -> no key_ack, no key_reject, FSM back in IDLE.
REQ-031 Hold key 7 low for 50 cycles -> exactly one key_ack, sec_ones=7; release then re-press 7 -> second key_ack, sec_tens=7.
REQ-032 clear_entry asserted in the COMMIT cycle of digit 9 -> all digits 0, digit_count=0, no key_ack, time_nonzero=0.
REQ-033 load_enable=0 while pressing 4 -> enablen=1, no key_ack, digits unchanged; reset during PRESS_DB -> all outputs 0.
